// File: rtl/dmem_load_store_initiator.sv
// ---------------------------------------------------------------------------
// dmem_load_store_initiator
//
// Purpose:
//   Initiator for a word-addressed data memory port. Takes byte/half/word
//   load and store requests from the execute stage over a valid/ready
//   handshake and drives the memory port. Load data is lane-selected and
//   sign- or zero-extended. The memory can only write whole words, so
//   sub-word stores are performed as read-modify-write (RD then WR).
//
// Parameters:
//   MEM_DEPTH   number of words in the target memory; word index >= MEM_DEPTH
//               is reported as an error
//
// Ports:
//   clk          in   1   clock
//   reset        in   1   synchronous, active-high reset
//   req_valid    in   1   request present
//   req_ready    out  1   request can be accepted (IDLE only)
//   req_write    in   1   1 = store, 0 = load
//   req_funct3   in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr     in   32  byte address
//   req_wdata    in   32  store data (low byte/half used for SB/SH)
//   resp_valid   out  1   one-cycle completion pulse
//   resp_rdata   out  32  extended load data; 0 for stores and errors
//   resp_err     out  1   misaligned / illegal funct3 / out of range
//   mem_addr     out  32  word-aligned byte address to memory
//   mem_din      out  32  write data to memory
//   mem_read     out  1   memory read enable
//   mem_write    out  1   memory write enable (committed at posedge)
//   mem_dout     in   32  asynchronous read data from memory
// ---------------------------------------------------------------------------
module dmem_load_store_initiator #(
  parameter int MEM_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  // -------------------------------------------------------------------------
  // Request checking (applied to the live request at the accept edge)
  // -------------------------------------------------------------------------
  logic w_legal;
  logic w_misalign;
  logic w_out_of_range;
  logic w_req_err;

  always_comb begin
    w_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !req_write;  // unsigned forms are loads only
      default:                w_legal = 1'b0;
    endcase
  end

  // funct3[1:0] encodes the access size for every legal code.
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  assign w_out_of_range = ({2'b00, req_addr[31:2]} >= DEPTH_W);

  assign w_req_err = !w_legal || w_misalign || w_out_of_range;

  // -------------------------------------------------------------------------
  // Load data lane select and extension
  // -------------------------------------------------------------------------
  function automatic logic [31:0] f_extend(input logic [2:0]  funct3,
                                           input logic [1:0]  offset,
                                           input logic [31:0] word);
    logic [7:0]  v_byte;
    logic [15:0] v_half;
    logic [31:0] v_out;
    case (offset)
      2'd0:    v_byte = word[7:0];
      2'd1:    v_byte = word[15:8];
      2'd2:    v_byte = word[23:16];
      default: v_byte = word[31:24];
    endcase
    v_half = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  v_out = {{24{v_byte[7]}}, v_byte};
      3'b001:  v_out = {{16{v_half[15]}}, v_half};
      3'b100:  v_out = {24'd0, v_byte};
      3'b101:  v_out = {16'd0, v_half};
      default: v_out = word;
    endcase
    return v_out;
  endfunction

  // -------------------------------------------------------------------------
  // Store merge: replicate the store data across lanes, then take the
  // selected lanes from it and the rest from the word captured in RD.
  // For SW every lane is selected, so r_word is don't-care there.
  // -------------------------------------------------------------------------
  logic [31:0] w_wsrc;
  logic [31:0] w_merged;

  always_comb begin
    w_wsrc = r_wdata;
    case (r_funct3[1:0])
      2'b00:   w_wsrc = {4{r_wdata[7:0]}};
      2'b01:   w_wsrc = {2{r_wdata[15:0]}};
      default: w_wsrc = r_wdata;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic w_lane_sel;
      assign w_lane_sel = (r_funct3[1:0] == 2'b10) ||
                          ((r_funct3[1:0] == 2'b01) && (r_addr[1] == LANE[1])) ||
                          ((r_funct3[1:0] == 2'b00) && (r_addr[1:0] == LANE));
      assign w_merged[8*gi +: 8] = w_lane_sel ? w_wsrc[8*gi +: 8] : r_word[8*gi +: 8];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Control FSM. Response outputs are registered and loaded on the
  // transition into RESP so they are valid for exactly the RESP cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_funct3     <= 3'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_word       <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            if (w_req_err) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
            end else if (req_write && (req_funct3[1:0] == 2'b10)) begin
              r_state <= S_WR;  // full word: no read needed
            end else begin
              r_state <= S_RD;  // loads and sub-word stores read first
            end
          end
        end

        S_RD: begin
          r_word <= mem_dout;
          if (r_write) begin
            r_state <= S_WR;
          end else begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= f_extend(r_funct3, r_addr[1:0], mem_dout);
          end
        end

        S_WR: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'd0;
        end

        default: begin  // S_RESP
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'd0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Memory strobes decode from state only, so they can never
  // overlap and are never raised in IDLE/RESP or on the error path.
  // -------------------------------------------------------------------------
  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  assign mem_read   = (r_state == S_RD);
  assign mem_write  = (r_state == S_WR);
  assign mem_addr   = {r_addr[31:2], 2'b00};
  assign mem_din    = (r_state == S_WR) ? w_merged : 32'd0;

endmodule
